// File: rtl/hash_matrix_unhash_pkg.sv
// ============================================================================
// Package : bsg_manycore_hash_pkg
// Brief   : Shared constants and helpers for the vcache address hash/unhash.
//           Hash rows, EVA field bounds, pivot columns, field typedef.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_manycore_hash_pkg;

  typedef logic [19:0] hash_field_t;

  localparam int EVA_W_lp        = 32;
  localparam int ADDR_W_lp       = 28;
  localparam int XCORD_W_lp      = 4;
  localparam int HASH_ROW_CNT_lp = 4;

  localparam int hash_lo_bit_lp = 6;
  localparam int hash_hi_bit_lp = 25;

  // Row r produces x_cord[r] = ^(row & eva[25:6]).
  localparam hash_field_t HASH_ROWS_lp [HASH_ROW_CNT_lp] =
    '{20'hD1E82, 20'h25F5E, 20'h7B8A1, 20'h42026};

  // Columns dropped from the compacted address; order matches the pivot
  // vector handed to insert_pivots (bit 0 -> column 19, ... bit 3 -> column 0).
  localparam int PIVOT_IDX_lp [HASH_ROW_CNT_lp] = '{19, 14, 2, 0};

  // Spread the 16 stored bits back over the non-pivot columns, pivots = 0.
  function automatic hash_field_t expand_compact(input logic [15:0] compact);
    return {1'b0, compact[15:12], 1'b0, compact[11:1], 1'b0, compact[0], 1'b0};
  endfunction

  // Drop recovered pivot bits into their columns.
  function automatic hash_field_t insert_pivots(input hash_field_t base,
                                                input logic [3:0]  piv);
    hash_field_t f;
    f = base;
    for (int i = 0; i < HASH_ROW_CNT_lp; i++) begin
      f[PIVOT_IDX_lp[i]] = piv[i];
    end
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hash_matrix_unhash_if.sv
// ============================================================================
// Interface: hash_matrix_unhash_if
// Brief    : Valid/ready input side and valid/yumi output side of the unhash
//            pipeline. master = producer/consumer (bench), slave = unhash.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hash_matrix_unhash_if #(parameter int tag_width_p = 8) ();
  import bsg_manycore_hash_pkg::*;

  logic                    v_i;
  logic                    ready_o;
  logic [XCORD_W_lp-1:0]   x_cord_i;
  logic [ADDR_W_lp-1:0]    addr_i;
  logic [tag_width_p-1:0]  tag_i;
  logic                    v_o;
  logic                    yumi_i;
  logic [EVA_W_lp-1:0]     eva_o;
  logic [tag_width_p-1:0]  tag_o;
  logic                    err_o;

  modport master (
    output v_i, x_cord_i, addr_i, tag_i, yumi_i,
    input  ready_o, v_o, eva_o, tag_o, err_o
  );

  modport slave (
    input  v_i, x_cord_i, addr_i, tag_i, yumi_i,
    output ready_o, v_o, eva_o, tag_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/hash_matrix_unhash_parity_row.sv
// ============================================================================
// Module  : hash_parity_row
// Brief   : One hash row: AND the 20-bit field with a constant mask, XOR-reduce.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_parity_row
  import bsg_manycore_hash_pkg::*;
#(
  parameter hash_field_t MASK_P = '0
) (
  input  hash_field_t data_i,
  output logic        parity_o
);

  assign parity_o = ^(data_i & MASK_P);

endmodule

`default_nettype wire

// File: rtl/hash_matrix_unhash.sv
// ============================================================================
// Module  : hash_matrix_unhash
// Brief   : Rebuilds a 32-bit EVA from a vcache index and the compacted line
//           address by recovering the four pivot bits. Two-stage valid/ready
//           pipeline, 1 beat/cycle, 2-cycle latency.
//           Optional macro HASH_MATRIX_UNHASH_CHECK_EN: re-hash the rebuilt
//           address and raise sticky err_o on a mismatch at output accept.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_matrix_unhash
  import bsg_manycore_hash_pkg::*;
#(
  parameter int data_width_p      = 32,
  parameter int x_subcord_width_p = 4,
  parameter int tag_width_p       = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  hash_matrix_unhash_if.slave  io
);

  if (data_width_p != EVA_W_lp) begin : g_bad_data_width
    $error("hash_matrix_unhash: data_width_p must be 32");
  end
  if (x_subcord_width_p != HASH_ROW_CNT_lp) begin : g_bad_xcord_width
    $error("hash_matrix_unhash: x_subcord_width_p must equal the hash row count");
  end

  // Stage 1 state
  logic                   s1_v_q, s1_v_d;
  logic [3:0]             k_q, k_d;
  logic [3:0]             x_cord_q, x_cord_d;
  logic [5:0]             hi_q, hi_d;
  logic [5:0]             lo_q, lo_d;
  logic [15:0]            compact_q, compact_d;
  logic [tag_width_p-1:0] tag1_q, tag1_d;
  // Stage 2 state (drives the outputs directly)
  logic                   s2_v_q, s2_v_d;
  logic [31:0]            eva_q, eva_d;
  logic [tag_width_p-1:0] tag2_q, tag2_d;

  logic        s2_adv;
  logic        ready;
  logic        s1_load;
  hash_field_t field_np;
  logic [3:0]  k_hash;
  logic        p19, p14, p2, p0;
  logic [31:0] eva_next;

  assign s2_adv  = !s2_v_q || io.yumi_i;
  assign ready   = !s1_v_q || s2_adv;
  assign s1_load = io.v_i && ready;

  // Partial hash over the known (non-pivot) bits only.
  assign field_np = expand_compact(io.addr_i[21:6]);

  for (genvar r = 0; r < HASH_ROW_CNT_lp; r++) begin : g_hash_row
    hash_parity_row #(.MASK_P(HASH_ROWS_lp[r])) u_row (
      .data_i   (field_np),
      .parity_o (k_hash[r])
    );
  end

  // Row structure makes the pivots triangular: rows 0,2,3 each see one pivot,
  // row 1 sees columns 14 and 2, so p2 is solved before p14.
  assign p2  = x_cord_q[3] ^ k_q[3];
  assign p14 = x_cord_q[1] ^ k_q[1] ^ p2;
  assign p19 = x_cord_q[0] ^ k_q[0];
  assign p0  = x_cord_q[2] ^ k_q[2];

  assign eva_next = {hi_q,
                     insert_pivots(expand_compact(compact_q), {p0, p2, p14, p19}),
                     lo_q};

  // Next-state for both stages: hold by default, shift when the stage advances.
  always_comb begin
    s1_v_d    = s1_v_q;
    k_d       = k_q;
    x_cord_d  = x_cord_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    compact_d = compact_q;
    tag1_d    = tag1_q;
    s2_v_d    = s2_v_q;
    eva_d     = eva_q;
    tag2_d    = tag2_q;

    if (s1_load) begin
      s1_v_d    = 1'b1;
      k_d       = k_hash;
      x_cord_d  = io.x_cord_i;
      hi_d      = io.addr_i[27:22];
      lo_d      = io.addr_i[5:0];
      compact_d = io.addr_i[21:6];
      tag1_d    = io.tag_i;
    end else if (s2_adv) begin
      s1_v_d = 1'b0;
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        eva_d  = eva_next;
        tag2_d = tag1_q;
      end
    end
  end

  // Pipeline registers; reset empties both stages and clears the outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v_q    <= 1'b0;
      k_q       <= '0;
      x_cord_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      compact_q <= '0;
      tag1_q    <= '0;
      s2_v_q    <= 1'b0;
      eva_q     <= '0;
      tag2_q    <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      k_q       <= k_d;
      x_cord_q  <= x_cord_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      compact_q <= compact_d;
      tag1_q    <= tag1_d;
      s2_v_q    <= s2_v_d;
      eva_q     <= eva_d;
      tag2_q    <= tag2_d;
    end
  end

  assign io.ready_o = ready;
  assign io.v_o     = s2_v_q;
  assign io.eva_o   = eva_q;
  assign io.tag_o   = tag2_q;

`ifdef HASH_MATRIX_UNHASH_CHECK_EN
  logic [3:0] rehash;
  logic       mis_q, mis_d;
  logic       err_q, err_d;

  for (genvar r = 0; r < HASH_ROW_CNT_lp; r++) begin : g_chk_row
    hash_parity_row #(.MASK_P(HASH_ROWS_lp[r])) u_row (
      .data_i   (eva_next[hash_hi_bit_lp:hash_lo_bit_lp]),
      .parity_o (rehash[r])
    );
  end

  // Capture the mismatch with the beat; flag it only when the beat is taken.
  always_comb begin
    mis_d = mis_q;
    err_d = err_q;
    if (s2_adv && s1_v_q) begin
      mis_d = (rehash != x_cord_q);
    end
    if (io.yumi_i && s2_v_q && mis_q) begin
      err_d = 1'b1;
    end
  end

  // Mismatch tag and sticky error flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end

  assign io.err_o = err_q;

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) io.yumi_i |-> io.v_o
  );
`else
  assign io.err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hash_matrix_unhash.sv
// ============================================================================
// Module  : tb_hash_matrix_unhash
// Brief   : Directed and randomised checks for hash_matrix_unhash.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hash_matrix_unhash;

  localparam int TAG_W = 8;
  localparam logic [19:0] ROW0 = 20'hD1E82;
  localparam logic [19:0] ROW1 = 20'h25F5E;
  localparam logic [19:0] ROW2 = 20'h7B8A1;
  localparam logic [19:0] ROW3 = 20'h42026;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hash_matrix_unhash_if #(.tag_width_p(TAG_W)) bus ();

  hash_matrix_unhash #(
    .data_width_p      (32),
    .x_subcord_width_p (4),
    .tag_width_p       (TAG_W)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [3:0] model_hash(input logic [31:0] e);
    logic [19:0] f;
    f = e[25:6];
    return {^(f & ROW3), ^(f & ROW2), ^(f & ROW1), ^(f & ROW0)};
  endfunction

  function automatic logic [27:0] model_addr(input logic [31:0] e);
    logic [19:0] f;
    logic [15:0] c;
    int j;
    f = e[25:6];
    c = '0;
    j = 0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0 && i != 2 && i != 14 && i != 19) begin
        c[j[3:0]] = f[i];
        j++;
      end
    end
    return {e[31:26], c, e[5:0]};
  endfunction

  task automatic idle_inputs();
    bus.v_i      = 1'b0;
    bus.yumi_i   = 1'b0;
    bus.x_cord_i = '0;
    bus.addr_i   = '0;
    bus.tag_i    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.v_o !== 1'b0)     begin bad++; $display("FAIL reset_v_o: got %b want 0", bus.v_o); end
    total++; if (bus.eva_o !== 32'h0)  begin bad++; $display("FAIL reset_eva_o: got %h want 0", bus.eva_o); end
    total++; if (bus.tag_o !== 8'h0)   begin bad++; $display("FAIL reset_tag_o: got %h want 0", bus.tag_o); end
    total++; if (bus.err_o !== 1'b0)   begin bad++; $display("FAIL reset_err_o: got %b want 0", bus.err_o); end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_o: got %b want 1", bus.ready_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [3:0]  dx [7];
    logic [27:0] da [7];
    logic [31:0] de [7];
    dx = '{4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    da = '{28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h000_0040, 28'hFC0_003F};
    de = '{32'h0000_0000, 32'h0000_0040, 32'h0200_0000, 32'h0010_0000,
           32'h0010_0100, 32'h0200_0180, 32'hFC00_003F};
    for (int i = 0; i < 7; i++) begin
      bus.v_i      = 1'b1;
      bus.x_cord_i = dx[i];
      bus.addr_i   = da[i];
      bus.tag_i    = 8'hA0 + 8'(i);
      @(negedge clk);
      bus.v_i = 1'b0;
      total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL dir%0d_early_v_o: got %b want 0", i, bus.v_o); end
      @(negedge clk);
      total++; if (bus.v_o !== 1'b1) begin bad++; $display("FAIL dir%0d_v_o: got %b want 1", i, bus.v_o); end
      total++; if (bus.eva_o !== de[i]) begin bad++; $display("FAIL dir%0d_eva: got %h want %h", i, bus.eva_o, de[i]); end
      total++; if (bus.tag_o !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL dir%0d_tag: got %h want %h", i, bus.tag_o, 8'hA0 + 8'(i)); end
      bus.yumi_i = 1'b1;
      @(negedge clk);
      bus.yumi_i = 1'b0;
      total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL dir%0d_drain_v_o: got %b want 0", i, bus.v_o); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] evas [8];
    int sent = 0, got = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
    int ready_seen [4];
    int exp_ready [4];
    for (int i = 0; i < 8; i++) evas[i] = $urandom;
    idle_inputs();
    while (got < 8 && cyc < 100) begin
      bus.yumi_i = bus.v_o;
      if (bus.v_o) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        total++;
        if (bus.eva_o !== evas[got] || bus.tag_o !== 8'h10 + 8'(got)) begin
          bad++;
          $display("FAIL b2b_beat%0d: got eva=%h tag=%h want eva=%h tag=%h",
                   got, bus.eva_o, bus.tag_o, evas[got], 8'h10 + 8'(got));
        end
        got++;
      end
      bus.v_i = (sent < 8);
      if (sent < 8) begin
        bus.x_cord_i = model_hash(evas[sent]);
        bus.addr_i   = model_addr(evas[sent]);
        bus.tag_i    = 8'h10 + 8'(sent);
      end
      #1;
      if (bus.v_i) begin
        total++;
        if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready beat%0d: got %b want 1", sent, bus.ready_o); end
        if (bus.ready_o) sent++;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (got != 8 || last_cyc - first_cyc != 7) begin
      bad++;
      $display("FAIL b2b_rate: got %0d beats over %0d cycles want 8 over 8", got, last_cyc - first_cyc + 1);
    end

    // Stall: consumer never accepts, so ready must drop once both stages fill.
    idle_inputs();
    exp_ready = '{1, 1, 0, 0};
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      bus.v_i      = 1'b1;
      bus.x_cord_i = model_hash(evas[sent]);
      bus.addr_i   = model_addr(evas[sent]);
      bus.tag_i    = 8'h20 + 8'(sent);
      #1;
      ready_seen[c] = int'(bus.ready_o);
      if (bus.ready_o) sent++;
      @(negedge clk);
    end
    bus.v_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (ready_seen[c] != exp_ready[c]) begin
        bad++;
        $display("FAIL stall_ready cycle%0d: got %0d want %0d", c, ready_seen[c], exp_ready[c]);
      end
    end
    got = 0; cyc = 0;
    while (got < 2 && cyc < 20) begin
      bus.yumi_i = bus.v_o;
      if (bus.v_o) begin
        total++;
        if (bus.eva_o !== evas[got] || bus.tag_o !== 8'h20 + 8'(got)) begin
          bad++;
          $display("FAIL stall_drain%0d: got eva=%h tag=%h want eva=%h tag=%h",
                   got, bus.eva_o, bus.tag_o, evas[got], 8'h20 + 8'(got));
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.yumi_i = 1'b0;
    total++; if (got != 2) begin bad++; $display("FAIL stall_drain_count: got %0d want 2", got); end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [39:0] q [$];
    logic [39:0] exp_b;
    logic [31:0] cur_eva;
    logic [7:0]  cur_tag;
    int sent = 0, got = 0, cyc = 0;
    idle_inputs();
    cur_eva = $urandom;
    cur_tag = 8'h00;
    while (got < N && cyc < 60000) begin
      bus.yumi_i = bus.v_o && ($urandom_range(3) != 0);
      if (bus.yumi_i) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL random_extra: got eva=%h tag=%h want no beat", bus.eva_o, bus.tag_o);
        end else begin
          exp_b = q.pop_front();
          if (bus.eva_o !== exp_b[31:0] || bus.tag_o !== exp_b[39:32]) begin
            bad++;
            $display("FAIL random_beat%0d: got eva=%h tag=%h want eva=%h tag=%h",
                     got, bus.eva_o, bus.tag_o, exp_b[31:0], exp_b[39:32]);
          end
        end
        got++;
      end
      bus.v_i      = (sent < N) && ($urandom_range(3) != 0);
      bus.x_cord_i = model_hash(cur_eva);
      bus.addr_i   = model_addr(cur_eva);
      bus.tag_i    = cur_tag;
      #1;
      if (bus.v_i && bus.ready_o) begin
        q.push_back({cur_tag, cur_eva});
        sent++;
        cur_eva = $urandom;
        cur_tag = cur_tag + 8'd1;
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    total++; if (got != N) begin bad++; $display("FAIL random_count: got %0d want %0d", got, N); end
    repeat (3) @(negedge clk);
    total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL random_dup: got v_o=%b want 0", bus.v_o); end
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL random_err: got %b want 0", bus.err_o); end
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    bus.v_i      = 1'b1;
    bus.x_cord_i = 4'b0100;
    bus.tag_i    = 8'h55;
    @(negedge clk);
    bus.x_cord_i = 4'b0001;
    bus.tag_i    = 8'h66;
    @(negedge clk);
    bus.v_i = 1'b0;
    total++; if (bus.v_o !== 1'b1) begin bad++; $display("FAIL midrst_loaded: got v_o=%b want 1", bus.v_o); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.v_o !== 1'b0)    begin bad++; $display("FAIL midrst_async_v_o: got %b want 0", bus.v_o); end
    total++; if (bus.eva_o !== 32'h0) begin bad++; $display("FAIL midrst_async_eva: got %h want 0", bus.eva_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (bus.v_o !== 1'b0) begin bad++; $display("FAIL midrst_stale cycle%0d: got v_o=%b want 0", c, bus.v_o); end
    end
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", bus.ready_o); end
  endtask

`ifdef HASH_MATRIX_UNHASH_CHECK_EN
  task automatic test_check();
    idle_inputs();
    bus.v_i      = 1'b1;
    bus.x_cord_i = 4'b0100;
    @(negedge clk);
    bus.v_i = 1'b0;
    force dut.k_q = 4'b0001;
    @(negedge clk);
    release dut.k_q;
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL chk_before_accept: got %b want 0", bus.err_o); end
    bus.yumi_i = 1'b1;
    @(negedge clk);
    bus.yumi_i = 1'b0;
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL chk_err_set: got %b want 1", bus.err_o); end
    repeat (3) @(negedge clk);
    total++; if (bus.err_o !== 1'b1) begin bad++; $display("FAIL chk_err_sticky: got %b want 1", bus.err_o); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL chk_err_reset: got %b want 0", bus.err_o); end
    @(negedge clk);
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
`ifdef HASH_MATRIX_UNHASH_CHECK_EN
    test_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
